// File: rtl/rat_cu_pkg.sv
// rat_cu_pkg: shared types and constants for the RAT control unit.
//   state_t      - control FSM states
//   OP_*         - full 7-bit opcodes {IR[17:13], IR[1:0]}
//   H5_*         - 5-bit opcodes of the immediate forms (IR[1:0] ignored)
//   ALU_*        - ALU_SEL codes
//   PC_MUX_*, RF_SEL_*, SCR_A_* - datapath mux selects
//   ctrl_t       - bundle of every control strobe except ALU_SEL
package rat_cu_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_INTR
  } state_t;

  localparam logic [6:0] OP_CMP   = 7'b0001000;
  localparam logic [6:0] OP_MOV   = 7'b0001001;
  localparam logic [6:0] OP_LD    = 7'b0001010;
  localparam logic [6:0] OP_ST    = 7'b0001011;
  localparam logic [6:0] OP_BRN   = 7'b0010000;
  localparam logic [6:0] OP_CALL  = 7'b0010001;
  localparam logic [6:0] OP_BREQ  = 7'b0010010;
  localparam logic [6:0] OP_BRNE  = 7'b0010011;
  localparam logic [6:0] OP_BRCS  = 7'b0010100;
  localparam logic [6:0] OP_BRCC  = 7'b0010101;
  localparam logic [6:0] OP_LSL   = 7'b0100000;
  localparam logic [6:0] OP_LSR   = 7'b0100001;
  localparam logic [6:0] OP_ROL   = 7'b0100010;
  localparam logic [6:0] OP_ROR   = 7'b0100011;
  localparam logic [6:0] OP_ASR   = 7'b0100100;
  localparam logic [6:0] OP_PUSH  = 7'b0100101;
  localparam logic [6:0] OP_POP   = 7'b0100110;
  localparam logic [6:0] OP_WSP   = 7'b0101000;
  localparam logic [6:0] OP_RSP   = 7'b0101001;
  localparam logic [6:0] OP_CLC   = 7'b0110000;
  localparam logic [6:0] OP_SEC   = 7'b0110001;
  localparam logic [6:0] OP_RET   = 7'b0110010;
  localparam logic [6:0] OP_SEI   = 7'b0110100;
  localparam logic [6:0] OP_CLI   = 7'b0110101;
  localparam logic [6:0] OP_RETID = 7'b0110110;
  localparam logic [6:0] OP_RETIE = 7'b0110111;

  localparam logic [4:0] H5_IN   = 5'b11001;
  localparam logic [4:0] H5_OUT  = 5'b11010;
  localparam logic [4:0] H5_MOVI = 5'b11011;
  localparam logic [4:0] H5_LDI  = 5'b11100;
  localparam logic [4:0] H5_STI  = 5'b11101;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDC = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBC = 4'd3;
  localparam logic [3:0] ALU_CMP  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_EXOR = 4'd7;
  localparam logic [3:0] ALU_TEST = 4'd8;
  localparam logic [3:0] ALU_LSL  = 4'd9;
  localparam logic [3:0] ALU_LSR  = 4'd10;
  localparam logic [3:0] ALU_ROL  = 4'd11;
  localparam logic [3:0] ALU_ROR  = 4'd12;
  localparam logic [3:0] ALU_ASR  = 4'd13;
  localparam logic [3:0] ALU_MOV  = 4'd14;

  localparam logic [1:0] PC_MUX_IMM = 2'd0;
  localparam logic [1:0] PC_MUX_SCR = 2'd1;
  localparam logic [1:0] PC_MUX_VEC = 2'd2;

  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_SCR = 2'd1;
  localparam logic [1:0] RF_SEL_SP  = 2'd2;
  localparam logic [1:0] RF_SEL_IN  = 2'd3;

  localparam logic [1:0] SCR_A_Y    = 2'd0;
  localparam logic [1:0] SCR_A_IMM  = 2'd1;
  localparam logic [1:0] SCR_A_SP   = 2'd2;
  localparam logic [1:0] SCR_A_SPM1 = 2'd3;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_inc;
    logic [1:0] pc_mux_sel;
    logic       alu_opy_sel;
    logic       rf_wr;
    logic [1:0] rf_wr_sel;
    logic       sp_ld;
    logic       sp_incr;
    logic       sp_decr;
    logic       scr_we;
    logic [1:0] scr_addr_sel;
    logic       scr_data_sel;
    logic       flg_c_set;
    logic       flg_c_clr;
    logic       flg_c_ld;
    logic       flg_z_ld;
    logic       flg_ld_sel;
    logic       flg_shad_ld;
    logic       i_set;
    logic       i_clr;
    logic       rst;
    logic       io_strb;
  } ctrl_t;

  // Low three opcode bits of the reg-reg / immediate ALU group:
  // 0..3 are the logic ops, 4..7 the arithmetic ops.
  function automatic logic [3:0] alu_grp_code(input logic [2:0] sel);
    case (sel)
      3'd0:    return ALU_AND;
      3'd1:    return ALU_OR;
      3'd2:    return ALU_EXOR;
      3'd3:    return ALU_TEST;
      3'd4:    return ALU_ADD;
      3'd5:    return ALU_ADDC;
      3'd6:    return ALU_SUB;
      default: return ALU_SUBC;
    endcase
  endfunction

endpackage

// File: rtl/rat_cu_decode.sv
// rat_cu_decode: combinational execute-cycle decoder.
//   opcode_hi  - IR[17:13]
//   opcode_lo  - IR[1:0]
//   c_flag, z_flag - current flags (branch conditions)
//   ctrl       - full set of execute strobes for this instruction
//   alu_sel    - ALU function select
//   is_read    - instruction reads scratch RAM (LD, POP, RET, RETID, RETIE)
module rat_cu_decode
  import rat_cu_pkg::*;
#(
  parameter int ALU_SEL_W = 4
) (
  input  logic [4:0]           opcode_hi,
  input  logic [1:0]           opcode_lo,
  input  logic                 c_flag,
  input  logic                 z_flag,
  output ctrl_t                ctrl,
  output logic [ALU_SEL_W-1:0] alu_sel,
  output logic                 is_read
);

  logic [6:0] opcode;
  logic [2:0] grp_sel;
  logic       alu_grp;

  assign opcode  = {opcode_hi, opcode_lo};
  // Reg-reg ALU group is 0000xxx; immediate group is HI5 10xxx.
  assign alu_grp = (opcode[6:3] == 4'b0000) || (opcode_hi[4:3] == 2'b10);
  assign grp_sel = opcode_hi[4] ? opcode_hi[2:0] : opcode[2:0];

  always_comb begin
    ctrl    = '0;
    alu_sel = '0;
    is_read = 1'b0;

    if (alu_grp) begin
      ctrl.alu_opy_sel = opcode_hi[4];
      alu_sel          = ALU_SEL_W'(alu_grp_code(grp_sel));
      ctrl.flg_z_ld    = 1'b1;
      ctrl.flg_c_clr   = ~grp_sel[2];
      ctrl.flg_c_ld    = grp_sel[2];
      ctrl.rf_wr       = (grp_sel != 3'd3);
    end else if (opcode_hi[4]) begin
      case (opcode_hi)
        H5_IN: begin
          ctrl.rf_wr     = 1'b1;
          ctrl.rf_wr_sel = RF_SEL_IN;
        end
        H5_OUT: ctrl.io_strb = 1'b1;
        H5_MOVI: begin
          ctrl.alu_opy_sel = 1'b1;
          alu_sel          = ALU_SEL_W'(ALU_MOV);
          ctrl.rf_wr       = 1'b1;
        end
        H5_LDI: begin
          is_read           = 1'b1;
          ctrl.scr_addr_sel = SCR_A_IMM;
          ctrl.rf_wr        = 1'b1;
          ctrl.rf_wr_sel    = RF_SEL_SCR;
        end
        H5_STI: begin
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_A_IMM;
        end
        default: ;
      endcase
    end else begin
      case (opcode)
        OP_CMP: begin
          alu_sel       = ALU_SEL_W'(ALU_CMP);
          ctrl.flg_c_ld = 1'b1;
          ctrl.flg_z_ld = 1'b1;
        end
        OP_MOV: begin
          alu_sel    = ALU_SEL_W'(ALU_MOV);
          ctrl.rf_wr = 1'b1;
        end
        OP_LD: begin
          is_read           = 1'b1;
          ctrl.scr_addr_sel = SCR_A_Y;
          ctrl.rf_wr        = 1'b1;
          ctrl.rf_wr_sel    = RF_SEL_SCR;
        end
        OP_ST: begin
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_A_Y;
        end
        OP_BRN:  ctrl.pc_ld = 1'b1;
        OP_BREQ: ctrl.pc_ld = z_flag;
        OP_BRNE: ctrl.pc_ld = ~z_flag;
        OP_BRCS: ctrl.pc_ld = c_flag;
        OP_BRCC: ctrl.pc_ld = ~c_flag;
        OP_CALL: begin
          ctrl.pc_ld        = 1'b1;
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_A_SPM1;
          ctrl.scr_data_sel = 1'b1;
          ctrl.sp_decr      = 1'b1;
        end
        OP_LSL, OP_LSR, OP_ROL, OP_ROR, OP_ASR: begin
          alu_sel       = ALU_SEL_W'(ALU_LSL + {1'b0, opcode[2:0]});
          ctrl.rf_wr    = 1'b1;
          ctrl.flg_c_ld = 1'b1;
          ctrl.flg_z_ld = 1'b1;
        end
        OP_PUSH: begin
          ctrl.scr_we       = 1'b1;
          ctrl.scr_addr_sel = SCR_A_SPM1;
          ctrl.sp_decr      = 1'b1;
        end
        OP_POP: begin
          is_read           = 1'b1;
          ctrl.scr_addr_sel = SCR_A_SP;
          ctrl.rf_wr        = 1'b1;
          ctrl.rf_wr_sel    = RF_SEL_SCR;
          ctrl.sp_incr      = 1'b1;
        end
        OP_WSP: ctrl.sp_ld = 1'b1;
        OP_RSP: begin
          ctrl.rf_wr     = 1'b1;
          ctrl.rf_wr_sel = RF_SEL_SP;
        end
        OP_CLC: ctrl.flg_c_clr = 1'b1;
        OP_SEC: ctrl.flg_c_set = 1'b1;
        OP_SEI: ctrl.i_set     = 1'b1;
        OP_CLI: ctrl.i_clr     = 1'b1;
        OP_RET, OP_RETID, OP_RETIE: begin
          is_read           = 1'b1;
          ctrl.scr_addr_sel = SCR_A_SP;
          ctrl.pc_ld        = 1'b1;
          ctrl.pc_mux_sel   = PC_MUX_SCR;
          ctrl.sp_incr      = 1'b1;
          if (opcode != OP_RET) begin
            ctrl.flg_ld_sel = 1'b1;
            ctrl.flg_c_ld   = 1'b1;
            ctrl.flg_z_ld   = 1'b1;
            ctrl.i_clr      = (opcode == OP_RETID);
            ctrl.i_set      = (opcode == OP_RETIE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rat_cu_pipe_int.sv
// rat_cu_pipe_int: multi-cycle RAT control unit with scratch-RAM wait
// states and interrupt entry.
//   CLK, RESET (sync, active-high)
//   OPCODE_HI_5, OPCODE_LOW_2 - instruction opcode fields
//   INT - pending, already-masked interrupt; C_FLAG, Z_FLAG - flags
//   Outputs: PC, ALU, register-file, stack, scratch, flag, I-flag,
//   datapath-reset and I/O strobe controls (all combinational).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_INIT  | datapath reset (RST) for one cycle
// S_FETCH | PC increment, IR is loaded from ROM
// S_EXEC  | execute; read-class with SCR_WAIT>0 only presents the address
// S_WAIT  | scratch-RAM read wait; completion strobes on counter 0
// S_INTR  | interrupt entry: push PC, shadow flags, jump to vector
module rat_cu_pipe_int
  import rat_cu_pkg::*;
#(
  parameter int SCR_WAIT  = 0,
  parameter int ALU_SEL_W = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [4:0]           OPCODE_HI_5,
  input  logic [1:0]           OPCODE_LOW_2,
  input  logic                 INT,
  input  logic                 C_FLAG,
  input  logic                 Z_FLAG,
  output logic                 PC_LD,
  output logic                 PC_INC,
  output logic [1:0]           PC_MUX_SEL,
  output logic                 ALU_OPY_SEL,
  output logic [ALU_SEL_W-1:0] ALU_SEL,
  output logic                 RF_WR,
  output logic [1:0]           RF_WR_SEL,
  output logic                 SP_LD,
  output logic                 SP_INCR,
  output logic                 SP_DECR,
  output logic                 SCR_WE,
  output logic [1:0]           SCR_ADDR_SEL,
  output logic                 SCR_DATA_SEL,
  output logic                 FLG_C_SET,
  output logic                 FLG_C_CLR,
  output logic                 FLG_C_LD,
  output logic                 FLG_Z_LD,
  output logic                 FLG_LD_SEL,
  output logic                 FLG_SHAD_LD,
  output logic                 I_SET,
  output logic                 I_CLR,
  output logic                 RST,
  output logic                 IO_STRB
);

  localparam bit         HAS_WAIT = (SCR_WAIT != 0);
  localparam logic [1:0] CNT_INIT = HAS_WAIT ? 2'(SCR_WAIT - 1) : 2'd0;

  state_t                 ps, ns;
  logic [1:0]             cnt;
  logic                   cnt_ld, cnt_dec;
  ctrl_t                  dec_ctrl, ctrl;
  logic [ALU_SEL_W-1:0]   dec_alu_sel, alu_sel;
  logic                   dec_is_read;

  rat_cu_decode #(.ALU_SEL_W(ALU_SEL_W)) u_decode (
    .opcode_hi (OPCODE_HI_5),
    .opcode_lo (OPCODE_LOW_2),
    .c_flag    (C_FLAG),
    .z_flag    (Z_FLAG),
    .ctrl      (dec_ctrl),
    .alu_sel   (dec_alu_sel),
    .is_read   (dec_is_read)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ps  <= S_INIT;
      cnt <= 2'd0;
    end else begin
      ps <= ns;
      if (cnt_ld)
        cnt <= CNT_INIT;
      else if (cnt_dec)
        cnt <= cnt - 2'd1;
    end
  end

  always_comb begin
    ns      = ps;
    ctrl    = '0;
    alu_sel = '0;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;

    case (ps)
      S_INIT: begin
        ctrl.rst = 1'b1;
        ns       = S_FETCH;
      end
      S_FETCH: begin
        ctrl.pc_inc = 1'b1;
        ns          = S_EXEC;
      end
      S_EXEC: begin
        if (dec_is_read && HAS_WAIT) begin
          // Address only; the completion strobes wait for the data.
          ctrl.scr_addr_sel = dec_ctrl.scr_addr_sel;
          cnt_ld            = 1'b1;
          ns                = S_WAIT;
        end else begin
          ctrl    = dec_ctrl;
          alu_sel = dec_alu_sel;
          ns      = INT ? S_INTR : S_FETCH;
        end
      end
      S_WAIT: begin
        if (cnt != 2'd0) begin
          ctrl.scr_addr_sel = dec_ctrl.scr_addr_sel;
          cnt_dec           = 1'b1;
        end else begin
          ctrl    = dec_ctrl;
          alu_sel = dec_alu_sel;
          ns      = INT ? S_INTR : S_FETCH;
        end
      end
      S_INTR: begin
        ctrl.pc_ld        = 1'b1;
        ctrl.pc_mux_sel   = PC_MUX_VEC;
        ctrl.scr_we       = 1'b1;
        ctrl.scr_addr_sel = SCR_A_SPM1;
        ctrl.scr_data_sel = 1'b1;
        ctrl.sp_decr      = 1'b1;
        ctrl.flg_shad_ld  = 1'b1;
        ctrl.i_clr        = 1'b1;
        ns                = S_FETCH;
      end
      default: ns = S_INIT;
    endcase
  end

  assign PC_LD        = ctrl.pc_ld;
  assign PC_INC       = ctrl.pc_inc;
  assign PC_MUX_SEL   = ctrl.pc_mux_sel;
  assign ALU_OPY_SEL  = ctrl.alu_opy_sel;
  assign ALU_SEL      = alu_sel;
  assign RF_WR        = ctrl.rf_wr;
  assign RF_WR_SEL    = ctrl.rf_wr_sel;
  assign SP_LD        = ctrl.sp_ld;
  assign SP_INCR      = ctrl.sp_incr;
  assign SP_DECR      = ctrl.sp_decr;
  assign SCR_WE       = ctrl.scr_we;
  assign SCR_ADDR_SEL = ctrl.scr_addr_sel;
  assign SCR_DATA_SEL = ctrl.scr_data_sel;
  assign FLG_C_SET    = ctrl.flg_c_set;
  assign FLG_C_CLR    = ctrl.flg_c_clr;
  assign FLG_C_LD     = ctrl.flg_c_ld;
  assign FLG_Z_LD     = ctrl.flg_z_ld;
  assign FLG_LD_SEL   = ctrl.flg_ld_sel;
  assign FLG_SHAD_LD  = ctrl.flg_shad_ld;
  assign I_SET        = ctrl.i_set;
  assign I_CLR        = ctrl.i_clr;
  assign RST          = ctrl.rst;
  assign IO_STRB      = ctrl.io_strb;

endmodule

// File: tb/tb_rat_cu_pipe_int.sv
// tb_rat_cu_pipe_int: directed test of the RAT control unit with a
// two-cycle scratch-RAM read latency.
module tb_rat_cu_pipe_int;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [4:0] OPCODE_HI_5 = 5'd0;
  logic [1:0] OPCODE_LOW_2 = 2'd0;
  logic       INT = 1'b0;
  logic       C_FLAG = 1'b0;
  logic       Z_FLAG = 1'b0;

  logic       PC_LD, PC_INC, ALU_OPY_SEL, RF_WR, SP_LD, SP_INCR, SP_DECR;
  logic       SCR_WE, SCR_DATA_SEL, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD;
  logic       FLG_LD_SEL, FLG_SHAD_LD, I_SET, I_CLR, RST, IO_STRB;
  logic [1:0] PC_MUX_SEL, RF_WR_SEL, SCR_ADDR_SEL;
  logic [3:0] ALU_SEL;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_inc;
    logic [1:0] pc_mux_sel;
    logic       alu_opy_sel;
    logic [3:0] alu_sel;
    logic       rf_wr;
    logic [1:0] rf_wr_sel;
    logic       sp_ld;
    logic       sp_incr;
    logic       sp_decr;
    logic       scr_we;
    logic [1:0] scr_addr_sel;
    logic       scr_data_sel;
    logic       flg_c_set;
    logic       flg_c_clr;
    logic       flg_c_ld;
    logic       flg_z_ld;
    logic       flg_ld_sel;
    logic       flg_shad_ld;
    logic       i_set;
    logic       i_clr;
    logic       rst;
    logic       io_strb;
  } o_t;

  o_t got, e;
  int n_checks = 0;
  int n_fail = 0;

  assign got = {PC_LD, PC_INC, PC_MUX_SEL, ALU_OPY_SEL, ALU_SEL, RF_WR, RF_WR_SEL,
                SP_LD, SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL,
                FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD,
                I_SET, I_CLR, RST, IO_STRB};

  rat_cu_pipe_int #(.SCR_WAIT(2), .ALU_SEL_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .OPCODE_HI_5(OPCODE_HI_5), .OPCODE_LOW_2(OPCODE_LOW_2),
    .INT(INT), .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG),
    .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_MUX_SEL(PC_MUX_SEL), .ALU_OPY_SEL(ALU_OPY_SEL),
    .ALU_SEL(ALU_SEL), .RF_WR(RF_WR), .RF_WR_SEL(RF_WR_SEL), .SP_LD(SP_LD),
    .SP_INCR(SP_INCR), .SP_DECR(SP_DECR), .SCR_WE(SCR_WE), .SCR_ADDR_SEL(SCR_ADDR_SEL),
    .SCR_DATA_SEL(SCR_DATA_SEL), .FLG_C_SET(FLG_C_SET), .FLG_C_CLR(FLG_C_CLR),
    .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD), .FLG_LD_SEL(FLG_LD_SEL),
    .FLG_SHAD_LD(FLG_SHAD_LD), .I_SET(I_SET), .I_CLR(I_CLR), .RST(RST), .IO_STRB(IO_STRB)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present an opcode during FETCH and advance into EXEC.
  task automatic go_exec(input logic [6:0] op);
    OPCODE_HI_5  = op[6:2];
    OPCODE_LOW_2 = op[1:0];
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    e = '0; e.rst = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_held: got %h expected %h", got, e); end
    RESET = 1'b0;
    OPCODE_HI_5 = 5'b00001; OPCODE_LOW_2 = 2'b00;
    #1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL init_after_release: got %h expected %h", got, e); end
    tick();
    e = '0; e.pc_inc = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL first_fetch: got %h expected %h", got, e); end
    tick();
    e = '0; e.alu_sel = 4'd0; e.rf_wr = 1'b1; e.flg_c_ld = 1'b1; e.flg_z_ld = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL add_exec: got %h expected %h", got, e); end
    tick();
  endtask

  task automatic test_alu();
    go_exec(7'b0000011);
    e = '0; e.alu_sel = 4'd8; e.flg_c_clr = 1'b1; e.flg_z_ld = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL test_exec: got %h expected %h", got, e); end
    tick();
    go_exec(7'b1010011);
    e = '0; e.alu_opy_sel = 1'b1; e.alu_sel = 4'd0; e.rf_wr = 1'b1;
    e.flg_c_ld = 1'b1; e.flg_z_ld = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL addi_exec: got %h expected %h", got, e); end
    tick();
    go_exec(7'b0100100);
    e = '0; e.alu_sel = 4'd13; e.rf_wr = 1'b1; e.flg_c_ld = 1'b1; e.flg_z_ld = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL asr_exec: got %h expected %h", got, e); end
    tick();
  endtask

  task automatic test_branch();
    Z_FLAG = 1'b0;
    go_exec(7'b0010010);
    e = '0;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL breq_not_taken: got %h expected %h", got, e); end
    tick();
    Z_FLAG = 1'b1;
    go_exec(7'b0010010);
    e = '0; e.pc_ld = 1'b1; e.pc_mux_sel = 2'd0;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL breq_taken: got %h expected %h", got, e); end
    tick();
    Z_FLAG = 1'b0;
    go_exec(7'b0010001);
    e = '0; e.pc_ld = 1'b1; e.scr_we = 1'b1; e.scr_addr_sel = 2'd3;
    e.scr_data_sel = 1'b1; e.sp_decr = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL call_exec: got %h expected %h", got, e); end
    tick();
  endtask

  task automatic test_pop_wait();
    go_exec(7'b0100110);
    e = '0; e.scr_addr_sel = 2'd2;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL pop_exec: got %h expected %h", got, e); end
    tick();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL pop_wait1: got %h expected %h", got, e); end
    tick();
    e = '0; e.scr_addr_sel = 2'd2; e.rf_wr = 1'b1; e.rf_wr_sel = 2'd1; e.sp_incr = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL pop_wait2: got %h expected %h", got, e); end
    tick();
    e = '0; e.pc_inc = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL pop_then_fetch: got %h expected %h", got, e); end
  endtask

  task automatic test_interrupt();
    go_exec(7'b0001001);
    INT = 1'b1;
    #1;
    e = '0; e.alu_sel = 4'd14; e.rf_wr = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL mov_exec: got %h expected %h", got, e); end
    tick();
    e = '0; e.pc_ld = 1'b1; e.pc_mux_sel = 2'd2; e.scr_we = 1'b1; e.scr_addr_sel = 2'd3;
    e.scr_data_sel = 1'b1; e.sp_decr = 1'b1; e.flg_shad_ld = 1'b1; e.i_clr = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL intr_entry: got %h expected %h", got, e); end
    tick();
    e = '0; e.pc_inc = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL intr_then_fetch: got %h expected %h", got, e); end
    INT = 1'b0;
    // RETIE; INT raised during the non-final cycles must be ignored
    go_exec(7'b0110111);
    INT = 1'b1;
    #1;
    e = '0; e.scr_addr_sel = 2'd2;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL retie_exec: got %h expected %h", got, e); end
    tick();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL retie_wait1: got %h expected %h", got, e); end
    INT = 1'b0;
    tick();
    e = '0; e.scr_addr_sel = 2'd2; e.pc_ld = 1'b1; e.pc_mux_sel = 2'd1; e.sp_incr = 1'b1;
    e.flg_ld_sel = 1'b1; e.flg_c_ld = 1'b1; e.flg_z_ld = 1'b1; e.i_set = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL retie_wait2: got %h expected %h", got, e); end
    tick();
    e = '0; e.pc_inc = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL retie_then_fetch: got %h expected %h", got, e); end
  endtask

  task automatic test_reset_mid_wait();
    go_exec(7'b1110010);
    e = '0; e.scr_addr_sel = 2'd1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL ldi_exec: got %h expected %h", got, e); end
    tick();
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL ldi_wait1: got %h expected %h", got, e); end
    RESET = 1'b1;
    tick();
    e = '0; e.rst = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL reset_mid_wait: got %h expected %h", got, e); end
    RESET = 1'b0;
    tick();
    e = '0; e.pc_inc = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL fetch_after_reset: got %h expected %h", got, e); end
  endtask

  task automatic test_misc();
    go_exec(7'b0111111);
    e = '0;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL undefined_nop: got %h expected %h", got, e); end
    tick();
    go_exec(7'b1101001);
    e = '0; e.io_strb = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL out_exec: got %h expected %h", got, e); end
    tick();
    go_exec(7'b0110001);
    e = '0; e.flg_c_set = 1'b1;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL sec_exec: got %h expected %h", got, e); end
    tick();
    go_exec(7'b0101001);
    e = '0; e.rf_wr = 1'b1; e.rf_wr_sel = 2'd2;
    n_checks++;
    if (got !== e) begin n_fail++; $display("FAIL rsp_exec: got %h expected %h", got, e); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_pop_wait();
    test_interrupt();
    test_reset_mid_wait();
    test_misc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
